// File: rtl/narrow_pkg.sv
// Shared constants and types for the 16-to-8 bit sign narrower.
// Width defaults, FIFO state encoding, mode encoding and 8-bit saturation limits.
package narrow_pkg;

    localparam int DEF_IN_W  = 16;
    localparam int DEF_OUT_W = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b10
    } fifo_state_e;

    localparam logic MODE_SAT   = 1'b1;
    localparam logic MODE_TRUNC = 1'b0;

    localparam logic [7:0] SAT_POS = 8'h7F;
    localparam logic [7:0] SAT_NEG = 8'h80;

endpackage

// File: rtl/narrow_fifo2.sv
// Two-entry FIFO with a three-state occupancy machine; slot 0 is always the head.
// A simultaneous push/pop with one entry replaces the head in place.
module narrow_fifo2
    import narrow_pkg::*;
#(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);

    fifo_state_e  state_q;
    fifo_state_e  state_d;
    logic [W-1:0] mem_q [2];
    logic [W-1:0] mem_d [2];
    logic         push_ok;
    logic         pop_ok;

    assign full_o  = (state_q == FULL);
    assign empty_o = (state_q == EMPTY);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign dout_o  = mem_q[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        mem_d[0] = mem_q[0];
        mem_d[1] = mem_q[1];
        case (state_q)
            EMPTY: begin
                if (push_ok) begin
                    state_d  = ONE;
                    mem_d[0] = din_i;
                end
            end
            ONE: begin
                if (push_ok && pop_ok) begin
                    mem_d[0] = din_i;
                end else if (push_ok) begin
                    state_d  = FULL;
                    mem_d[1] = din_i;
                end else if (pop_ok) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                // Push is blocked here, so only a pop can move the tail forward.
                if (pop_ok) begin
                    state_d  = ONE;
                    mem_d[0] = mem_q[1];
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_slot
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                mem_q[gi] <= '0;
            end else begin
                mem_q[gi] <= mem_d[gi];
            end
        end
    end

endmodule

// File: rtl/sign_narrower_16in_8out.sv
// Narrows two's-complement words to bytes (saturate or truncate), flags and counts
// non-representable inputs, and buffers results in a two-entry output FIFO.
module sign_narrower_16in_8out
    import narrow_pkg::*;
#(
    parameter int IN_W  = DEF_IN_W,
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             ovf_sticky,
    output logic [CNT_W-1:0] ovf_count,
    input  logic             clr_stats
);

    localparam int HI_W = IN_W - OUT_W + 1;
    localparam logic [OUT_W-1:0] SAT_POS_W = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG_W = {1'b1, {(OUT_W-1){1'b0}}};

    logic [HI_W-1:0]  upper;
    logic             ovf;
    logic [OUT_W-1:0] byte_n;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [OUT_W:0]   fifo_dout;

    logic             sticky_q;
    logic             sticky_d;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Representable exactly when the sign bit of the byte matches every discarded bit.
    assign upper = in_data[IN_W-1:OUT_W-1];
    assign ovf   = !((&upper) || !(|upper));

    always_comb begin
        byte_n = in_data[OUT_W-1:0];
        if (ovf && (in_sat == MODE_SAT)) begin
            byte_n = in_data[IN_W-1] ? SAT_NEG_W : SAT_POS_W;
        end
    end

    assign in_ready  = !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    narrow_fifo2 #(
        .W (OUT_W + 1)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   ({byte_n, ovf}),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign out_data = fifo_dout[OUT_W:1];
    assign out_ovf  = fifo_dout[0];

    // A clear wins over a same-cycle overflow; that overflow is dropped.
    always_comb begin
        sticky_d = sticky_q;
        count_d  = count_q;
        if (clr_stats) begin
            sticky_d = 1'b0;
            count_d  = '0;
        end else if (push && ovf) begin
            sticky_d = 1'b1;
            if (count_q != '1) begin
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= 1'b0;
            count_q  <= '0;
        end else begin
            sticky_q <= sticky_d;
            count_q  <= count_d;
        end
    end

    assign ovf_sticky = sticky_q;
    assign ovf_count  = count_q;

endmodule

// File: tb/tb_sign_narrower_16in_8out.sv
// Randomised and directed bench for sign_narrower_16in_8out against a queue-based model.
module tb_sign_narrower_16in_8out;
    import narrow_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        in_sat;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        ovf_sticky;
    logic [7:0]  ovf_count;
    logic        clr_stats;

    sign_narrower_16in_8out dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sat     (in_sat),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_ovf    (out_ovf),
        .ovf_sticky (ovf_sticky),
        .ovf_count  (ovf_count),
        .clr_stats  (clr_stats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] word;
        logic [7:0]  b;
        logic        ovf;
    } exp_t;

    exp_t mq[$];
    int   m_count;
    bit   m_sticky;
    int   chk_cnt;
    int   pass_cnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: value range test on the signed integer, then pick the byte.
    function automatic exp_t ref_narrow(input logic [15:0] w, input logic sat);
        exp_t e;
        int   v;
        v = int'($signed(w));
        e.word = w;
        e.ovf  = (v > 127) || (v < -128);
        if (e.ovf && sat) begin
            e.b = (v < 0) ? SAT_NEG : SAT_POS;
        end else begin
            e.b = w[7:0];
        end
        return e;
    endfunction

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(mq.size() < 2));
        chk("ovf_sticky", 32'(ovf_sticky), 32'(m_sticky));
        chk("ovf_count", 32'(ovf_count), 32'(m_count));
        if (mq.size() != 0) begin
            chk("out_data", 32'(out_data), 32'(mq[0].b));
            chk("out_ovf", 32'(out_ovf), 32'(mq[0].ovf));
            if (!mq[0].ovf) begin
                chk("roundtrip", 32'({{8{out_data[7]}}, out_data}), 32'(mq[0].word));
            end
        end
    endtask

    // One cycle: drive after the falling edge, update the model at the rising edge,
    // then compare at the next falling edge.
    task automatic step(input logic v, input logic [15:0] d, input logic s,
                        input logic r, input logic c, output logic acc);
        exp_t e;
        logic pop;
        in_valid  = v;
        in_data   = d;
        in_sat    = s;
        out_ready = r;
        clr_stats = c;
        acc = v && (mq.size() < 2);
        pop = r && (mq.size() > 0);
        e   = ref_narrow(d, s);
        @(posedge clk);
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(e);
            if (e.ovf) begin
                m_sticky = 1'b1;
                if (m_count < 255) m_count++;
            end
            $display("accept word=%04h sat=%0b -> byte=%02h ovf=%0b", d, s, e.b, e.ovf);
        end
        if (c) begin
            m_sticky = 1'b0;
            m_count  = 0;
        end
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [15:0] rand_word();
        logic [15:0] bnd [8];
        logic [7:0]  b;
        bnd = '{16'h007F, 16'h0080, 16'hFF80, 16'hFF7F, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
        case ($urandom_range(0, 3))
            0: begin
                b = 8'($urandom);
                return {{8{b[7]}}, b};
            end
            1: return 16'($urandom);
            2: return bnd[$urandom_range(0, 7)];
            default: return 16'(int'($urandom_range(0, 600)) - 300);
        endcase
    endfunction

    initial begin
        logic        acc;
        logic        held;
        logic [15:0] w;
        logic [15:0] dir_words [4];
        logic [15:0] ovf_words [2];

        chk_cnt   = 0;
        pass_cnt  = 0;
        m_count   = 0;
        m_sticky  = 1'b0;
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        in_sat    = 1'b0;
        out_ready = 1'b0;
        clr_stats = 1'b0;

        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'h00);
        chk("rst_out_ovf", 32'(out_ovf), 32'd0);
        chk("rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("rst_count", 32'(ovf_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        check_all();

        // Representable words in saturate mode.
        dir_words = '{16'h0000, 16'h0003, 16'hFF83, 16'h007F};
        for (int i = 0; i < 4; i++) step(1'b1, dir_words[i], MODE_SAT, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);

        // Overflowing words, saturate then truncate.
        ovf_words = '{16'h0080, 16'h8000};
        for (int i = 0; i < 2; i++) step(1'b1, ovf_words[i], MODE_SAT, 1'b1, 1'b0, acc);
        for (int i = 0; i < 2; i++) step(1'b1, ovf_words[i], MODE_TRUNC, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
        chk("ovf_count_4", 32'(ovf_count), 32'd4);
        chk("ovf_sticky_set", 32'(ovf_sticky), 32'd1);

        // Backpressure: two accepted, third stalls until the buffer drains.
        step(1'b1, 16'h0011, MODE_SAT, 1'b0, 1'b0, acc);
        step(1'b1, 16'hFF22, MODE_SAT, 1'b0, 1'b0, acc);
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        step(1'b1, 16'h0033, MODE_SAT, 1'b0, 1'b0, acc);
        held = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step(held, 16'h0033, MODE_SAT, 1'b1, 1'b0, acc);
            if (acc) held = 1'b0;
        end

        // Sustained overflow stream until the counter saturates, then clear with overflow.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 300; i++) begin
            w = 16'($urandom);
            w[15:14] = ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10;
            step(1'b1, w, 1'($urandom_range(0, 1)), 1'b1, 1'b0, acc);
        end
        chk("cnt_saturated", 32'(ovf_count), 32'd255);
        step(1'b1, 16'h4000, MODE_SAT, 1'b1, 1'b1, acc);
        chk("clr_count", 32'(ovf_count), 32'd0);
        chk("clr_sticky", 32'(ovf_sticky), 32'd0);

        // Random traffic with random backpressure and occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 3) != 0), rand_word(), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 49) == 0), acc);
        end

        // Mid-stream asynchronous reset.
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 16'h1234, MODE_SAT, 1'b0, 1'b0, acc);
        step(1'b1, 16'h8765, MODE_TRUNC, 1'b0, 1'b0, acc);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_out_data", 32'(out_data), 32'h00);
        chk("mid_rst_sticky", 32'(ovf_sticky), 32'd0);
        chk("mid_rst_count", 32'(ovf_count), 32'd0);
        mq.delete();
        m_count  = 0;
        m_sticky = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_all();
        step(1'b1, 16'h0012, MODE_SAT, 1'b0, 1'b0, acc);
        chk("post_rst_valid", 32'(out_valid), 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0, acc);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
